// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the sync_fifo_p synchronous FIFO.
// Holds the default data width, pointer width, depth and occupancy
// thresholds, plus the operation encoding used by the count update.

package sync_fifo_pkg;

    // Default word width and pointer width; depth follows from the pointer.
    localparam int DEF_DATA_W       = 12;
    localparam int DEF_ADDR_W       = 3;
    localparam int DEF_DEPTH        = 1 << DEF_ADDR_W;

    // Default occupancy thresholds for the almost flags.
    localparam int DEF_ALMOST_FULL  = 6;
    localparam int DEF_ALMOST_EMPTY = 1;

    // What the FIFO actually does at a clock edge, after the full/empty
    // gating has been applied to the raw requests.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Folds the two accept strobes into a single operation code.
    function automatic fifo_op_e classify_op(input logic push_ok, input logic pop_ok);
        return fifo_op_e'({push_ok, pop_ok});
    endfunction

endpackage

// File: rtl/sync_fifo_p_if.sv
// Handshake bundle between a FIFO user (master) and sync_fifo_p (slave).
// Carries the push/pop requests, write data, registered read data and the
// occupancy flags. The overflow/underflow error flags only exist when the
// SYNC_FIFO_ERR_EN macro is defined.

interface sync_fifo_p_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
`ifdef SYNC_FIFO_ERR_EN
    logic              overflow;
    logic              underflow;
`endif

    // The user side drives requests and write data, and observes the rest.
    modport master (
        output push,
        output data_in,
        output pop,
        input  data_out,
        input  data_valid,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
`ifdef SYNC_FIFO_ERR_EN
        input  overflow,
        input  underflow,
`endif
        input  count
    );

    // The FIFO side sees requests and produces data and status.
    modport slave (
        input  push,
        input  data_in,
        input  pop,
        output data_out,
        output data_valid,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
`ifdef SYNC_FIFO_ERR_EN
        output overflow,
        output underflow,
`endif
        output count
    );

endinterface

// File: rtl/sync_fifo_p_sdp_ram.sv
// sdp_ram: simple dual-port storage array for sync_fifo_p.
// One write port and one synchronous read port sharing a single clock.
// There is deliberately no reset: contents are only ever read at addresses
// that were written since the FIFO last emptied, so stale words are harmless
// and the array can map onto plain block or distributed RAM.

module sdp_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the incoming word when the FIFO accepts a push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: register the addressed word on an accepted pop and hold it
    // otherwise, so the output stays stable between pops.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_p.sv
// sync_fifo_p: single-clock FIFO with registered read data and occupancy flags.
// Pointers, the occupancy count, the flags and the push/pop gating live
// here; the storage array is the sdp_ram sub-module.
// Optional feature: define SYNC_FIFO_ERR_EN to add sticky overflow and
// underflow outputs; without it, rejected requests are silently dropped.

module sync_fifo_p
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int ALMOST_FULL  = DEF_ALMOST_FULL,
    parameter int ALMOST_EMPTY = DEF_ALMOST_EMPTY
) (
    input  logic         clk,
    input  logic         reset,
    sync_fifo_p_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              valid_q;
    logic              loaded_q;
    logic [DATA_W-1:0] ram_q;

    logic              full_w;
    logic              empty_w;
    logic              push_ok;
    logic              pop_ok;
    fifo_op_e          op;

`ifdef SYNC_FIFO_ERR_EN
    logic              overflow_q;
    logic              underflow_q;
`endif

    // Flags are pure decodes of the registered count, each one independent.
    always_comb begin
        full_w           = (int'(count_q) == DEPTH);
        empty_w          = (count_q == '0);
        bus.full         = full_w;
        bus.empty        = empty_w;
        bus.almost_full  = (int'(count_q) >= ALMOST_FULL);
        bus.almost_empty = (int'(count_q) <= ALMOST_EMPTY);
    end

    // Gate the raw requests with the pre-edge flags. Because a full FIFO
    // refuses the push and an empty one refuses the pop, a simultaneous
    // request at either extreme degrades to a single operation, and the read
    // and write addresses can never collide in the same cycle.
    always_comb begin
        push_ok = bus.push && !full_w;
        pop_ok  = bus.pop  && !empty_w;
        op      = classify_op(push_ok, pop_ok);
    end

    sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // Pointers advance on their own accepted operation and wrap naturally
    // through the power-of-two address width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy count: up on a lone push, down on a lone pop, otherwise held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            case (op)
                OP_PUSH: count_q <= count_q + 1'b1;
                OP_POP:  count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // data_valid pulses for the cycle after each accepted pop. loaded_q
    // records that the RAM read register holds a real word since the last
    // reset; until then data_out reads as zero, which gives data_out an
    // immediate asynchronous clear without putting a reset on the RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            valid_q <= pop_ok;
            if (pop_ok) begin
                loaded_q <= 1'b1;
            end
        end
    end

    // Drive the read-side outputs and the count.
    always_comb begin
        bus.data_out   = loaded_q ? ram_q : '0;
        bus.data_valid = valid_q;
        bus.count      = count_q;
    end

`ifdef SYNC_FIFO_ERR_EN
    // Sticky error flags: overflow on a push refused because the FIFO is
    // full (a push that coincides with an accepted pop is a normal drop, not
    // an error), underflow on any pop refused because the FIFO is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.push && full_w && !pop_ok) begin
                overflow_q <= 1'b1;
            end
            if (bus.pop && empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Expose the sticky error flags.
    always_comb begin
        bus.overflow  = overflow_q;
        bus.underflow = underflow_q;
    end
`endif

endmodule

// File: tb/tb_sync_fifo_p.sv
// Directed self-checking bench for sync_fifo_p (DATA_W=12, ADDR_W=3,
// ALMOST_FULL=6, ALMOST_EMPTY=1). Error-flag checks are compiled in only
// when SYNC_FIFO_ERR_EN is defined.

module tb_sync_fifo_p;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sync_fifo_p_if #(.DATA_W(12), .ADDR_W(3)) bus ();

    sync_fifo_p #(
        .DATA_W       (12),
        .ADDR_W       (3),
        .ALMOST_FULL  (6),
        .ALMOST_EMPTY (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of requests, let the edge happen, then sample 1 unit
    // later with the requests returned to idle.
    task automatic apply_stimulus(input logic p, input logic q, input logic [11:0] d);
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
    endtask

    // Single comparison point.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_count", 32'(bus.count), 32'd0);
        check_output("rst_empty", 32'(bus.empty), 32'd1);
        check_output("rst_aempty", 32'(bus.almost_empty), 32'd1);
        check_output("rst_full", 32'(bus.full), 32'd0);
        check_output("rst_afull", 32'(bus.almost_full), 32'd0);
        check_output("rst_valid", 32'(bus.data_valid), 32'd0);
        check_output("rst_dout", 32'(bus.data_out), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 0x001..0x008.
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, 1'b0, 12'(i));
            check_output("fill_count", 32'(bus.count), 32'(i));
            check_output("fill_afull", 32'(bus.almost_full), (i >= 6) ? 32'd1 : 32'd0);
            check_output("fill_aempty", 32'(bus.almost_empty), (i <= 1) ? 32'd1 : 32'd0);
            check_output("fill_full", 32'(bus.full), (i == 8) ? 32'd1 : 32'd0);
            check_output("fill_empty", 32'(bus.empty), 32'd0);
        end

        // Push while full is dropped.
        apply_stimulus(1'b1, 1'b0, 12'h0FF);
        check_output("ovf_count", 32'(bus.count), 32'd8);
`ifdef SYNC_FIFO_ERR_EN
        check_output("ovf_flag", 32'(bus.overflow), 32'd1);
        check_output("ovf_no_udf", 32'(bus.underflow), 32'd0);
`endif

        // Drain in order.
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 12'h000);
            check_output("drain_dout", 32'(bus.data_out), 32'(i));
            check_output("drain_valid", 32'(bus.data_valid), 32'd1);
            check_output("drain_count", 32'(bus.count), 32'(8 - i));
        end
        apply_stimulus(1'b0, 1'b0, 12'h000);
        check_output("idle_valid", 32'(bus.data_valid), 32'd0);
        check_output("idle_dout_hold", 32'(bus.data_out), 32'h008);
        check_output("drained_empty", 32'(bus.empty), 32'd1);
        check_output("drained_aempty", 32'(bus.almost_empty), 32'd1);

        // Pop while empty is dropped.
        apply_stimulus(1'b0, 1'b1, 12'h000);
        check_output("udf_valid", 32'(bus.data_valid), 32'd0);
        check_output("udf_count", 32'(bus.count), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
        check_output("udf_flag", 32'(bus.underflow), 32'd1);
        check_output("ovf_held", 32'(bus.overflow), 32'd1);
`endif

        // Push+pop while empty: only the push is taken.
        apply_stimulus(1'b1, 1'b1, 12'h0A0);
        check_output("pp_empty_count", 32'(bus.count), 32'd1);
        check_output("pp_empty_valid", 32'(bus.data_valid), 32'd0);
        apply_stimulus(1'b0, 1'b1, 12'h000);
        check_output("pp_empty_dout", 32'(bus.data_out), 32'h0A0);
        check_output("pp_empty_valid2", 32'(bus.data_valid), 32'd1);

        // Wrap-around with three words in flight.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0, 12'(12'h101 + i));
        end
        check_output("wrap_prefill", 32'(bus.count), 32'd3);
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b1, 1'b1, 12'(12'h104 + k));
            check_output("wrap_dout", 32'(bus.data_out), 32'(12'h101 + k));
            check_output("wrap_valid", 32'(bus.data_valid), 32'd1);
            check_output("wrap_count", 32'(bus.count), 32'd3);
        end
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b1, 12'h000);
            check_output("wrap_tail", 32'(bus.data_out), 32'(12'h115 + k));
        end
        check_output("wrap_empty", 32'(bus.empty), 32'd1);

        // Push+pop while full: only the pop is taken.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b0, 12'(12'h201 + i));
        end
        check_output("pf_full", 32'(bus.full), 32'd1);
        apply_stimulus(1'b1, 1'b1, 12'h2FF);
        check_output("pf_count", 32'(bus.count), 32'd7);
        check_output("pf_dout", 32'(bus.data_out), 32'h201);
        check_output("pf_valid", 32'(bus.data_valid), 32'd1);
        check_output("pf_full_clr", 32'(bus.full), 32'd0);
        apply_stimulus(1'b1, 1'b0, 12'h209);
        check_output("pf_refill", 32'(bus.count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 12'h000);
            check_output("pf_order", 32'(bus.data_out), 32'(12'h202 + i));
        end

        // Reset asserted between edges in the middle of a burst.
        apply_stimulus(1'b1, 1'b0, 12'h301);
        apply_stimulus(1'b1, 1'b0, 12'h302);
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.data_in = 12'h303;
        @(posedge clk);
        #1;
        check_output("burst_valid", 32'(bus.data_valid), 32'd1);
        check_output("burst_count", 32'(bus.count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_count", 32'(bus.count), 32'd0);
        check_output("async_empty", 32'(bus.empty), 32'd1);
        check_output("async_valid", 32'(bus.data_valid), 32'd0);
        check_output("async_dout", 32'(bus.data_out), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
        check_output("async_ovf", 32'(bus.overflow), 32'd0);
        check_output("async_udf", 32'(bus.underflow), 32'd0);
`endif
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b0, 12'h3AA);
        check_output("post_rst_count", 32'(bus.count), 32'd1);
        apply_stimulus(1'b0, 1'b1, 12'h000);
        check_output("post_rst_dout", 32'(bus.data_out), 32'h3AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
